// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: per-layer sequencer for one fully-connected layer.
// Fires the CIM tile array, waits for it, then launches the func drain.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_start        : input vector available from previous stage
//   o_ready        : idle, can accept i_start
//   o_cim_start    : one-cycle pulse to all CIM tiles
//   i_cim_ready    : per-tile ready (1 = idle/done)
//   i_func_ready   : func unit idle
//   o_func_start   : start request to func unit (held in S_FUNC_REQ)
//   i_func_done    : func unit completion pulse
//   o_busy         : sequencing a pass (not idle, not error)
//   o_error        : sticky timeout flag
//   i_clear_error  : leave the error state
//   o_count        : completed passes, wrapping
module fc_layer_ctrl #(
    parameter int NUM_TILES = 4,
    parameter int TIMEOUT   = 1023,
    parameter int COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    output logic                 o_ready,
    output logic                 o_cim_start,
    input  logic [NUM_TILES-1:0] i_cim_ready,
    input  logic                 i_func_ready,
    output logic                 o_func_start,
    input  logic                 i_func_done,
    output logic                 o_busy,
    output logic                 o_error,
    input  logic                 i_clear_error,
    output logic [COUNT_W-1:0]   o_count
);

    // Timer never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_CIM,
        S_FUNC_REQ,
        S_FUNC_WAIT,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic          all_rdy;
    logic          timing;
    logic          exit_ok;
    logic          done_pass;

    assign all_rdy = &i_cim_ready;

    always_comb begin
        state_nx     = state;
        timing       = 1'b0;
        exit_ok      = 1'b0;
        done_pass    = 1'b0;
        o_ready      = 1'b0;
        o_cim_start  = 1'b0;
        o_func_start = 1'b0;
        o_busy       = 1'b1;
        o_error      = 1'b0;

        unique case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_start && all_rdy) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_cim_start = 1'b1;
                state_nx    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // Tiles acknowledge by dropping ready.
                timing  = 1'b1;
                exit_ok = !all_rdy;
                if (exit_ok) begin
                    state_nx = S_WAIT_CIM;
                end
            end
            S_WAIT_CIM: begin
                timing  = 1'b1;
                exit_ok = all_rdy && i_func_ready;
                if (exit_ok) begin
                    state_nx = S_FUNC_REQ;
                end
            end
            S_FUNC_REQ: begin
                // Done beats the accept: a one-cycle func busy
                // window must not strand us in S_FUNC_WAIT.
                o_func_start = 1'b1;
                timing       = 1'b1;
                exit_ok      = i_func_done || !i_func_ready;
                if (i_func_done) begin
                    state_nx  = S_IDLE;
                    done_pass = 1'b1;
                end else if (!i_func_ready) begin
                    state_nx = S_FUNC_WAIT;
                end
            end
            S_FUNC_WAIT: begin
                timing  = 1'b1;
                exit_ok = i_func_done;
                if (i_func_done) begin
                    state_nx  = S_IDLE;
                    done_pass = 1'b1;
                end
            end
            S_ERROR: begin
                o_busy  = 1'b0;
                o_error = 1'b1;
                if (i_clear_error) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // An exit seen in the final allowed cycle still wins.
        if (timing && !exit_ok && timer == T_LAST) begin
            state_nx  = S_ERROR;
            done_pass = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            o_count <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                timer <= '0;
            end else if (timing) begin
                timer <= timer + TW'(1);
            end
            if (done_pass) begin
                o_count <= o_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl: directed + randomized bench for fc_layer_ctrl.
// Expected waveforms come from per-pass phase-length arithmetic.
module tb_fc_layer_ctrl;

    localparam int NT = 4;
    localparam int TO = 15;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          o_ready;
    logic          o_cim_start;
    logic [NT-1:0] i_cim_ready;
    logic          i_func_ready;
    logic          o_func_start;
    logic          i_func_done;
    logic          o_busy;
    logic          o_error;
    logic          i_clear_error;
    logic [CW-1:0] o_count;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt;

    fc_layer_ctrl #(
        .NUM_TILES(NT),
        .TIMEOUT  (TO),
        .COUNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .o_ready      (o_ready),
        .o_cim_start  (o_cim_start),
        .i_cim_ready  (i_cim_ready),
        .i_func_ready (i_func_ready),
        .o_func_start (o_func_start),
        .i_func_done  (i_func_done),
        .o_busy       (o_busy),
        .o_error      (o_error),
        .i_clear_error(i_clear_error),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_outs(input logic er, input logic rd,
                              input logic bs, input logic cs,
                              input logic fs,
                              input logic [CW-1:0] cnt);
        chk("o_error", o_error, er);
        chk("o_ready", o_ready, rd);
        chk("o_busy", o_busy, bs);
        chk("o_cim_start", o_cim_start, cs);
        chk("o_func_start", o_func_start, fs);
        chk("o_count", o_count, cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst           = 1'b0;
        i_start       = 1'b0;
        i_cim_ready   = '1;
        i_func_ready  = 1'b1;
        i_func_done   = 1'b0;
        i_clear_error = 1'b0;
    endtask

    // One pass, cycle 0 = idle cycle in which i_start is offered.
    // a: WAIT_ACK cycles before tiles drop ready
    // b: extra cycles tiles stay busy after dropping
    // c: cycles func ready is low once tiles are ready again
    // f: FUNC_REQ cycles before func ready drops
    // g: cycles from func ready drop to done (0 = same cycle)
    // A phase length reaching TO never exits and must time out.
    task automatic run_pass(input int a, input int b, input int c,
                            input int f, input int g);
        int r, fin, err_at, last, fs_hi;
        logic bs_e, rd_e, er_e, fs_e;
        logic [CW-1:0] cnt0;
        logic [CW-1:0] cnt_e;
        cnt0   = exp_cnt;
        r      = 4 + a + b + c;
        fin    = r + f + g;
        err_at = -1;
        if (a >= TO)                  err_at = 2 + TO;
        else if (b + c >= TO)         err_at = 3 + a + TO;
        else if (f >= TO)             err_at = r + TO;
        else if (g >= 1 && g > TO)    err_at = r + f + 1 + TO;
        last  = (err_at >= 0) ? err_at : fin + 1;
        fs_hi = r + f;
        if (err_at >= 0 && fs_hi >= err_at) fs_hi = err_at - 1;

        for (int k = 0; k <= last; k++) begin
            er_e  = (err_at >= 0) && (k >= err_at);
            bs_e  = (k >= 1) &&
                    ((err_at >= 0) ? (k < err_at) : (k <= fin));
            rd_e  = !bs_e && !er_e;
            fs_e  = (k >= r) && (k <= fs_hi);
            cnt_e = cnt0;
            if (err_at < 0 && k > fin) cnt_e = cnt0 + CW'(1);
            check_outs(er_e, rd_e, bs_e, (k == 1), fs_e, cnt_e);
            if (k == last) begin
                drive_idle();
            end else begin
                i_start = (k == 0) || ($urandom_range(0, 3) == 0);
                if (k >= 2 + a && k <= 2 + a + b)
                    i_cim_ready = NT'($urandom_range(0, 14));
                else
                    i_cim_ready = '1;
                i_func_ready = !((k >= 3 + a + b &&
                                  k < 3 + a + b + c) ||
                                 (k >= r + f && k <= fin));
                i_func_done   = (k == fin);
                i_clear_error = ($urandom_range(0, 3) == 0);
                step();
            end
        end

        if (err_at >= 0) begin
            step();
            check_outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt0);
            i_start = 1'b1;
            step();
            check_outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cnt0);
            i_start       = 1'b0;
            i_clear_error = 1'b1;
            step();
            i_clear_error = 1'b0;
            check_outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, cnt0);
            exp_cnt = cnt0;
        end else begin
            exp_cnt = cnt0 + CW'(1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, c, f, g, sel;

        // Reset, with a start request ignored while held.
        drive_idle();
        rst     = 1'b1;
        i_start = 1'b1;
        step();
        step();
        exp_cnt = '0;
        check_outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
        drive_idle();

        // Nominal pass.
        run_pass(0, 9, 0, 1, 4);

        // Start held while one tile is not ready.
        for (int k = 0; k < 20; k++) begin
            i_start     = 1'b1;
            i_cim_ready = 4'b1011;
            step();
            check_outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
        end
        drive_idle();
        step();
        check_outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);

        // Tiles never acknowledge: timeout then clear.
        run_pass(TO + 3, 0, 0, 0, 0);

        // Done in the same cycle func ready falls.
        run_pass(0, 2, 0, 1, 0);

        // Reset during S_WAIT_CIM.
        drive_idle();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("rst_pre_cim_start", o_cim_start, 1'b1);
        i_cim_ready = '0;
        step();
        step();
        chk("rst_pre_busy", o_busy, 1'b1);
        rst = 1'b1;
        step();
        drive_idle();
        exp_cnt = '0;
        check_outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
        for (int k = 0; k < 6; k++) begin
            step();
            check_outs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
        end

        // Five passes from zero: count wraps 1,2,3,0,1.
        for (int p = 0; p < 5; p++) begin
            run_pass(p % 3, p, 0, p % 2, p + 1);
        end
        chk("wrap_final", o_count, 2'd1);

        // Randomized passes including timeout boundaries.
        for (int p = 0; p < 40; p++) begin
            sel = $urandom_range(0, 11);
            a   = $urandom_range(0, 4);
            b   = $urandom_range(0, 5);
            c   = $urandom_range(0, 3);
            f   = $urandom_range(0, 3);
            g   = $urandom_range(0, 5);
            case (sel)
                0: a = TO - 1;
                1: b = TO - 1 - c;
                2: f = TO - 1;
                3: g = TO;
                4: a = TO + 3;
                5: b = TO;
                6: f = TO + 2;
                7: g = TO + 1;
                default: ;
            endcase
            run_pass(a, b, c, f, g);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
